// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between I-miss fills, D-miss fills and write-through stores.
// Latency: grant one cycle after a request is seen in IDLE; fills stream at memory read latency.
// Backpressure: requesters hold their request until done/ack; stalls derive combinationally.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              i_stall,
    output logic              d_stall,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              d_wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int OFF_W = $clog2(2 * BLOCK_WORDS);
    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rcv_cnt;

    logic filling;
    logic issuing;
    logic rcv;
    logic last_rcv;

    assign filling  = (state == FILL_I) || (state == FILL_D);
    assign issuing  = filling && (issue_cnt != CNT_FULL);
    assign rcv      = filling && mem_valid;
    assign last_rcv = rcv && (rcv_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    rcv_cnt   <= '0;
                    // Stores win so the write-through path never waits behind a whole burst.
                    if (d_wr_req) begin
                        state <= WRITE;
                    end else if (d_req) begin
                        state <= FILL_D;
                        base  <= d_addr & BASE_MASK;
                    end else if (i_req) begin
                        state <= FILL_I;
                        base  <= i_addr & BASE_MASK;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                FILL_I, FILL_D: begin
                    if (issuing)
                        issue_cnt <= issue_cnt + CNT_ONE;
                    if (rcv)
                        rcv_cnt <= rcv_cnt + CNT_ONE;
                    // Burst ends on the last returned word, not the last issue.
                    if (last_rcv) begin
                        state     <= IDLE;
                        issue_cnt <= '0;
                        rcv_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_en    = (state == WRITE) || issuing;
    assign mem_wr    = (state == WRITE);
    assign mem_addr  = (state == WRITE) ? d_wr_addr : base + (ADDR_W'(issue_cnt) << 1);
    assign mem_wdata = d_wr_data;
    assign d_wr_ack  = (state == WRITE);

    assign i_fill_valid = rcv && (state == FILL_I);
    assign d_fill_valid = rcv && (state == FILL_D);
    assign fill_addr    = base + (ADDR_W'(rcv_cnt) << 1);
    assign fill_data    = mem_rdata;
    assign i_done       = last_rcv && (state == FILL_I);
    assign d_done       = last_rcv && (state == FILL_D);

    assign i_stall = i_req & ~i_done;
    assign d_stall = (d_req & ~d_done) | (d_wr_req & ~d_wr_ack);

    a_one_owner: assert property (@(posedge clk) disable iff (rst)
        !(i_fill_valid && d_fill_valid));
    a_idle_counters: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (issue_cnt == '0 && rcv_cnt == '0));
    a_issue_bound: assert property (@(posedge clk) disable iff (rst)
        issue_cnt <= CNT_FULL);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-burst fills plus multi-cycle corner sequences.
module tb_mem_arbiter;

    localparam logic [15:0] KEY = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        i_stall, d_stall, i_fill_valid, d_fill_valid;
    logic [15:0] fill_addr, fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        i_done, d_done, d_wr_ack, mem_en, mem_wr, mem_valid;
    logic        inj_valid;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .i_stall(i_stall), .d_stall(d_stall),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    // Memory model: two-cycle read latency, data = address ^ KEY.
    logic        pv0, pv1;
    logic [15:0] pa0, pa1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv0 <= 1'b0; pv1 <= 1'b0; pa0 <= '0; pa1 <= '0;
        end else begin
            pv0 <= mem_en & ~mem_wr; pa0 <= mem_addr;
            pv1 <= pv0;              pa1 <= pa0;
        end
    end
    assign mem_valid = pv1 | inj_valid;
    assign mem_rdata = pa1 ^ KEY;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-window record filled by watch()
    int          n_if, n_df, first_if, first_df, i_done_at, d_done_at, ack_at, drop_d_after;
    logic [15:0] if_a [8];
    logic [15:0] df_a [8];
    logic        en_log [64];
    logic        wr_log [64];
    logic [15:0] addr_log [64];
    logic [15:0] wd_log [64];

    task automatic watch(input int ncyc);
        n_if = 0; n_df = 0; first_if = -1; first_df = -1;
        i_done_at = -1; d_done_at = -1; ack_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            en_log[c] = mem_en; wr_log[c] = mem_wr;
            addr_log[c] = mem_addr; wd_log[c] = mem_wdata;
            if (i_fill_valid || d_fill_valid) begin
                chk("one_owner", {31'd0, i_fill_valid & d_fill_valid}, 32'd0);
                chk("fill_data", {16'd0, fill_data}, {16'd0, fill_addr ^ KEY});
            end
            if (d_fill_valid && i_req)
                chk("i_stall_during_d", {31'd0, i_stall}, 32'd1);
            if (i_fill_valid) begin
                if (first_if < 0) first_if = c;
                if (n_if < 8) if_a[n_if] = fill_addr;
                n_if++;
            end
            if (d_fill_valid) begin
                if (first_df < 0) first_df = c;
                if (n_df < 8) df_a[n_df] = fill_addr;
                n_df++;
                if (n_df == drop_d_after) d_req = 1'b0;
            end
            if (i_done) begin
                i_done_at = c;
                chk("i_stall_at_done", {31'd0, i_stall}, 32'd0);
                i_req = 1'b0;
            end
            if (d_done) begin
                d_done_at = c;
                d_req = 1'b0;
            end
            if (d_wr_ack) begin
                ack_at = c;
                d_wr_req = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        is_d;
        logic [15:0] addr;
        logic [15:0] exp_base;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b0, 16'h0036, 16'h0030};
        vecs[1] = '{1'b1, 16'h1234, 16'h1230};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFF0};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000};
        vecs[4] = '{1'b0, 16'h00FF, 16'h00F0};

        rst = 1'b1; inj_valid = 1'b0; drop_d_after = 0;
        i_req = 0; d_req = 0; d_wr_req = 0;
        i_addr = 0; d_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {23'd0, i_stall, d_stall, i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack, mem_en, mem_wr},
            32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

        // Single bursts: issue in cycles 0..7, fills in 2..9, done with the 8th.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_d) begin d_req = 1'b1; d_addr = vecs[v].addr; end
            else              begin i_req = 1'b1; i_addr = vecs[v].addr; end
            watch(14);
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("v%0d_issue%0d_en", v, k), {31'd0, en_log[k] & ~wr_log[k]}, 32'd1);
                chk($sformatf("v%0d_issue%0d_addr", v, k), {16'd0, addr_log[k]},
                    {16'd0, vecs[v].exp_base + 16'(2 * k)});
                chk($sformatf("v%0d_fill%0d_addr", v, k),
                    {16'd0, vecs[v].is_d ? df_a[k] : if_a[k]},
                    {16'd0, vecs[v].exp_base + 16'(2 * k)});
            end
            chk($sformatf("v%0d_issue_stop", v), {31'd0, en_log[8]}, 32'd0);
            chk($sformatf("v%0d_nfill", v), vecs[v].is_d ? n_df : n_if, 32'd8);
            chk($sformatf("v%0d_other_nfill", v), vecs[v].is_d ? n_if : n_df, 32'd0);
            chk($sformatf("v%0d_first_fill", v), vecs[v].is_d ? first_df : first_if, 32'd2);
            chk($sformatf("v%0d_done_at", v), vecs[v].is_d ? d_done_at : i_done_at, 32'd9);
        end

        // I and D raised together: D burst, one idle cycle, then I burst.
        i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_addr = 16'h0207;
        #1 chk("both_i_stall", {31'd0, i_stall}, 32'd1);
        watch(30);
        chk("both_first_df", first_df, 32'd2);
        chk("both_d_done", d_done_at, 32'd9);
        chk("both_df0", {16'd0, df_a[0]}, 32'h0200);
        chk("both_idle_gap", {31'd0, en_log[10]}, 32'd0);
        chk("both_i_issue0", {16'd0, addr_log[11]}, 32'h0040);
        chk("both_first_if", first_if, 32'd13);
        chk("both_i_done", i_done_at, 32'd20);
        chk("both_n_if", n_if, 32'd8);
        chk("both_n_df", n_df, 32'd8);

        // Store with I pending: one write cycle, idle, then I burst.
        d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
        i_req = 1'b1; i_addr = 16'h0022;
        #1 chk("wr_d_stall", {31'd0, d_stall}, 32'd1);
        watch(16);
        chk("wr_ack_at", ack_at, 32'd0);
        chk("wr_mem", {13'd0, en_log[0], wr_log[0], en_log[1], addr_log[0]}, {13'd0, 3'b110, 16'h0100});
        chk("wr_wdata", {16'd0, wd_log[0]}, 32'h0000BEEF);
        chk("wr_i_issue", {15'd0, wr_log[2], addr_log[2]}, {15'd0, 1'b0, 16'h0020});
        chk("wr_i_done", i_done_at, 32'd11);
        chk("wr_n_if", n_if, 32'd8);

        // D request withdrawn after the 3rd word: burst still drains.
        d_req = 1'b1; d_addr = 16'h0310; drop_d_after = 3;
        watch(14);
        drop_d_after = 0;
        chk("drop_n_df", n_df, 32'd8);
        chk("drop_d_done", d_done_at, 32'd9);
        chk("drop_last_addr", {16'd0, df_a[7]}, 32'h031E);

        // Reset after the 4th word: no done; a later request restarts from word 0.
        i_req = 1'b1; i_addr = 16'h0456;
        watch(6);
        chk("rst_pre_n_if", n_if, 32'd4);
        rst = 1'b1;
        #1 chk("rst_outputs",
            {27'd0, i_fill_valid, d_fill_valid, i_done, d_done, mem_en}, 32'd0);
        watch(2);
        chk("rst_no_fill", n_if, 32'd0);
        chk("rst_no_done", i_done_at, 32'hFFFFFFFF);
        rst = 1'b0;
        watch(14);
        chk("rst_restart_first", first_if, 32'd2);
        chk("rst_restart_a0", {16'd0, if_a[0]}, 32'h0450);
        chk("rst_restart_done", i_done_at, 32'd9);
        chk("rst_restart_n", n_if, 32'd8);

        // Stray mem_valid in IDLE is ignored.
        inj_valid = 1'b1;
        watch(1);
        inj_valid = 1'b0;
        chk("inj_no_fill", n_if + n_df, 32'd0);
        i_req = 1'b1; i_addr = 16'h0598;
        watch(14);
        chk("inj_a0", {16'd0, if_a[0]}, 32'h0590);
        chk("inj_done", i_done_at, 32'd9);
        chk("inj_n", n_if, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
